wb_dma_copy: RTL and testbench

//  Pipelined Wishbone initiator that copies LEN words from SRC to DST over a single

---
 rtl/yarc_dma_pkg.sv | 19 +
 rtl/dma_fifo.sv | 57 +++++
 rtl/wb_dma_copy.sv | 207 ++++++++++++++++++++
 tb/tb_wb_dma_copy.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/yarc_dma_pkg.sv
// Shared types and default widths for the Wishbone copy engine.
package yarc_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        GAP,
        WR,
        DONE,
        ABORT
    } dma_state_e;

    localparam int unsigned DMA_ADDR_W         = 32;
    localparam int unsigned DMA_DATA_W         = 32;
    localparam int unsigned DMA_LEN_W          = 16;
    localparam int unsigned DMA_FIFO_DEPTH     = 8;
    localparam int unsigned DMA_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/dma_fifo.sv
// Synchronous FIFO buffering one read chunk until the write burst drains it.
module dma_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/wb_dma_copy.sv
// Pipelined Wishbone initiator copying LEN words SRC -> DST in FIFO-sized chunks.
// Optional watchdog abort on missing acks: define WB_DMA_TIMEOUT_EN.
module wb_dma_copy
    import yarc_dma_pkg::*;
#(
    parameter int unsigned ADDR_W         = DMA_ADDR_W,
    parameter int unsigned DATA_W         = DMA_DATA_W,
    parameter int unsigned LEN_W          = DMA_LEN_W,
    parameter int unsigned FIFO_DEPTH     = DMA_FIFO_DEPTH,
    parameter int unsigned TIMEOUT_CYCLES = DMA_TIMEOUT_CYCLES
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   src_addr_i,
    input  logic [ADDR_W-1:0]   dst_addr_i,
    input  logic [LEN_W-1:0]    len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                cyc_o,
    output logic                stb_o,
    output logic                lock_o,
    output logic                we_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [DATA_W/8-1:0] sel_o,
    output logic [DATA_W-1:0]   wdata_o,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic                ack_i,
    input  logic                stall_i,
    input  logic                err_i,
    input  logic                rty_i
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  chunk_q, chunk_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  acked_q, acked_d;
    logic [CNT_W-1:0]  acked_next;

    logic              cyc;
    logic              stb;
    logic              accept;
    logic              ack_v;
    logic              abort;
    logic              timeout;
    logic              chunk_done;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    function automatic logic [CNT_W-1:0] chunk_of(input logic [LEN_W-1:0] n);
        if (n > LEN_W'(FIFO_DEPTH)) return CNT_W'(FIFO_DEPTH);
        return CNT_W'(n);
    endfunction

    assign cyc    = (state_q == RD) || (state_q == WR);
    assign stb    = cyc && (issued_q != chunk_q);
    assign accept = stb && !stall_i;
    // Acks with nothing outstanding are stray and must not advance the count.
    assign ack_v      = cyc && ack_i && (issued_q != acked_q);
    assign acked_next = ack_v ? acked_q + CNT_W'(1) : acked_q;
    assign chunk_done = (acked_next == chunk_q);
    assign abort      = cyc && (err_i || rty_i || timeout);

`ifdef WB_DMA_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (!cyc || ack_i) wd_d = '0;
        else               wd_d = wd_q + WD_W'(1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) wd_q <= '0;
        else         wd_q <= wd_d;
    end

    assign timeout = cyc && !ack_i && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        chunk_d  = chunk_q;
        issued_d = issued_q;
        acked_d  = acked_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d    = src_addr_i;
                    dst_d    = dst_addr_i;
                    rem_d    = len_i;
                    chunk_d  = chunk_of(len_i);
                    issued_d = '0;
                    acked_d  = '0;
                    state_d  = (len_i == '0) ? DONE : RD;
                end
            end
            RD: begin
                if (accept) begin
                    issued_d = issued_q + CNT_W'(1);
                    src_d    = src_q + ADDR_W'(1);
                end
                acked_d = acked_next;
                if (abort)           state_d = ABORT;
                else if (chunk_done) state_d = GAP;
            end
            GAP: begin
                issued_d = '0;
                acked_d  = '0;
                // An empty FIFO means the last write chunk has drained.
                if (fifo_count == '0) begin
                    chunk_d = chunk_of(rem_q);
                    state_d = RD;
                end else begin
                    state_d = WR;
                end
            end
            WR: begin
                if (accept) begin
                    issued_d = issued_q + CNT_W'(1);
                    dst_d    = dst_q + ADDR_W'(1);
                end
                acked_d = acked_next;
                if (abort) begin
                    state_d = ABORT;
                end else if (chunk_done) begin
                    rem_d   = rem_q - LEN_W'(chunk_q);
                    state_d = (rem_d == '0) ? DONE : GAP;
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            chunk_q  <= '0;
            issued_q <= '0;
            acked_q  <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            chunk_q  <= chunk_d;
            issued_q <= issued_d;
            acked_q  <= acked_d;
        end
    end

    assign fifo_push  = (state_q == RD) && ack_v && !fifo_full;
    assign fifo_pop   = (state_q == WR) && accept;
    assign fifo_flush = (state_q == ABORT);

    dma_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (rdata_i),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE);
    assign err_o   = (state_q == ABORT);
    assign cyc_o   = cyc;
    assign stb_o   = stb;
    assign lock_o  = 1'b0;
    assign we_o    = (state_q == WR);
    assign addr_o  = (state_q == RD) ? src_q : ((state_q == WR) ? dst_q : '0);
    assign sel_o   = stb ? '1 : '0;
    assign wdata_o = ((state_q == WR) && stb && !fifo_empty) ? fifo_head : '0;

endmodule

// File: tb/tb_wb_dma_copy.sv
// Bench for wb_dma_copy: behavioural pipelined WB memory, vector table plus corner sequences.
module tb_wb_dma_copy;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len;
    logic        busy, done, err, cyc, stb, lock, we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  sel;
    logic        ack = 1'b0, stall = 1'b0, err_in = 1'b0, rty = 1'b0;

    always #5 clk = ~clk;

    wb_dma_copy #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .LEN_W          (16),
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .start_i    (start),
        .src_addr_i (src_addr),
        .dst_addr_i (dst_addr),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .cyc_o      (cyc),
        .stb_o      (stb),
        .lock_o     (lock),
        .we_o       (we),
        .addr_o     (addr),
        .sel_o      (sel),
        .wdata_o    (wdata),
        .rdata_i    (rdata),
        .ack_i      (ack),
        .stall_i    (stall),
        .err_i      (err_in),
        .rty_i      (rty)
    );

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return {8'hD0, a[7:0], ~a[7:0], a[7:0] ^ 8'h3C};
    endfunction

    // Responder: one-cycle ack latency, optional stall toggle, error and ack suppression.
    bit [31:0] mem [256];
    bit        mem_valid [256];
    bit        stall_mode = 0, err_arm = 0, ack_suppress = 0;
    int        rd_n = 0;

    always @(posedge clk) begin
        logic acc;
        logic [7:0] a;
        acc = cyc && stb && !stall;
        a   = addr[7:0];
        if (acc && we) begin
            mem[a]       <= wdata;
            mem_valid[a] <= 1'b1;
        end
        ack    <= acc && !ack_suppress && !(err_arm && !we && rd_n == 1);
        err_in <= acc && !we && err_arm && rd_n == 1;
        rdata  <= mem_valid[a] ? mem[a] : pattern(addr);
        if (!busy)          rd_n <= 0;
        else if (acc && !we) rd_n <= rd_n + 1;
        stall  <= stall_mode ? !stall : 1'b0;
    end

    // Monitor, sampled mid-cycle.
    int done_cnt = 0, err_cnt = 0, burst_cnt = 0, rd_beats = 0, wr_beats = 0;
    int order_bad = 0, stall_bad = 0, gap_bad = 0, sel_bad = 0, abort_late = 0;
    int cyc_n = 0, first_stb_cyc = -1, err_cyc = -1, xfer_bursts = 0, low_run = 0;
    logic [31:0] exp_rd = '0, exp_wr = '0, paddr = '0, pwdata = '0;
    logic cyc_prev = 0, hold_prev = 0, pwe = 0, err_prev = 0;

    always @(negedge clk) begin
        cyc_n++;
        if (start && !busy) begin
            exp_rd = src_addr; exp_wr = dst_addr;
            xfer_bursts = 0; low_run = 0; first_stb_cyc = -1;
        end
        if (done) done_cnt++;
        if (err) begin err_cnt++; err_cyc = cyc_n; end
        if (cyc && !cyc_prev) begin
            burst_cnt++;
            if (xfer_bursts > 0 && low_run != 1) gap_bad++;
            xfer_bursts++;
        end
        if (cyc) low_run = 0; else if (busy) low_run++;
        if (stb && !stall) begin
            if (we) begin wr_beats++; if (addr != exp_wr) order_bad++; exp_wr++; end
            else    begin rd_beats++; if (addr != exp_rd) order_bad++; exp_rd++; end
        end
        if (stb && first_stb_cyc < 0) first_stb_cyc = cyc_n;
        if (hold_prev && stb && (addr != paddr || we != pwe || wdata != pwdata)) stall_bad++;
        hold_prev = stb && stall; paddr = addr; pwe = we; pwdata = wdata;
        if ((stb && sel != 4'hF) || lock) sel_bad++;
        if (err_prev && cyc) abort_late++;
        err_prev = (err_in || rty) && cyc;
        cyc_prev = cyc;
    end

    int n_checks = 0, n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        int d0, e0;
        bit ended;
        d0 = done_cnt; e0 = err_cnt; ended = 0;
        @(posedge clk); #1;
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (done_cnt != d0 || err_cnt != e0) begin ended = 1; break; end
            @(posedge clk); #1;
        end
        if (!ended) check("xfer_timeout", 1, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        bit          stall;
        int          bursts;
    } vec_t;

    initial begin
        vec_t vecs [5];
        int d0, e0, b0, r0, w0, bad;
        logic [7:0] idx;

        vecs[0] = '{32'h10, 32'h20, 16'd3, 1'b0, 2};
        vecs[1] = '{32'h40, 32'h80, 16'd20, 1'b0, 6};
        vecs[2] = '{32'h30, 32'hC0, 16'd8, 1'b1, 2};
        vecs[3] = '{32'hFFFF_FFFE, 32'h60, 16'd4, 1'b0, 2};
        vecs[4] = '{32'h04, 32'hA0, 16'd9, 1'b1, 4};

        rstn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(|{busy, done, err, cyc, stb, lock, we, addr, sel, wdata}), 0);
        rstn = 1'b1;

        for (int v = 0; v < 5; v++) begin
            stall_mode = vecs[v].stall;
            d0 = done_cnt; e0 = err_cnt; b0 = burst_cnt; r0 = rd_beats; w0 = wr_beats;
            run_xfer(vecs[v].src, vecs[v].dst, vecs[v].len);
            check($sformatf("v%0d_done", v), done_cnt - d0, 1);
            check($sformatf("v%0d_err", v), err_cnt - e0, 0);
            check($sformatf("v%0d_bursts", v), burst_cnt - b0, vecs[v].bursts);
            check($sformatf("v%0d_rd_beats", v), rd_beats - r0, 32'(vecs[v].len));
            check($sformatf("v%0d_wr_beats", v), wr_beats - w0, 32'(vecs[v].len));
            bad = 0;
            for (int i = 0; i < int'(vecs[v].len); i++) begin
                idx = 8'(vecs[v].dst + 32'(i));
                if (!mem_valid[idx] || mem[idx] != pattern(vecs[v].src + 32'(i))) bad++;
            end
            check($sformatf("v%0d_data", v), bad, 0);
            check($sformatf("v%0d_busy_after", v), 32'(busy), 0);
        end
        stall_mode = 0;

        // Zero length: done the cycle after start, bus untouched.
        b0 = burst_cnt;
        @(posedge clk); #1;
        src_addr = 32'h10; dst_addr = 32'hD0; len = 16'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("len0_done", 32'(done), 1);
        check("len0_cyc", 32'(cyc), 0);
        @(posedge clk); #1;
        check("len0_done_once", 32'(done), 0);
        check("len0_busy", 32'(busy), 0);
        check("len0_bursts", burst_cnt - b0, 0);

        // Error on the second read response aborts before any write.
        d0 = done_cnt; e0 = err_cnt; w0 = wr_beats;
        err_arm = 1;
        run_xfer(32'h30, 32'hB0, 16'd5);
        err_arm = 0;
        check("abort_err", err_cnt - e0, 1);
        check("abort_done", done_cnt - d0, 0);
        check("abort_wr_beats", wr_beats - w0, 0);
        check("abort_busy", 32'(busy), 0);

        // Buffer must be empty after the abort.
        d0 = done_cnt;
        run_xfer(32'h10, 32'h70, 16'd3);
        check("post_abort_done", done_cnt - d0, 1);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            idx = 8'(32'h70 + 32'(i));
            if (mem[idx] != pattern(32'h10 + 32'(i))) bad++;
        end
        check("post_abort_data", bad, 0);

`ifdef WB_DMA_TIMEOUT_EN
        d0 = done_cnt; e0 = err_cnt;
        ack_suppress = 1;
        run_xfer(32'h10, 32'hE8, 16'd4);
        ack_suppress = 0;
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_done", done_cnt - d0, 0);
        check("timeout_latency", err_cyc - first_stb_cyc, 16);
`endif

        // Reset in the middle of a burst clears outputs asynchronously, no pulses.
        d0 = done_cnt; e0 = err_cnt;
        @(posedge clk); #1;
        src_addr = 32'h40; dst_addr = 32'hE0; len = 16'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !cyc; i++) begin @(posedge clk); #1; end
        check("rst_mid_in_burst", 32'(cyc), 1);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("rst_mid_outputs", 32'(|{busy, done, err, cyc, stb, lock, we, addr, sel, wdata}), 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_done", done_cnt - d0, 0);
        check("rst_mid_err", err_cnt - e0, 0);

        check("addr_order", order_bad, 0);
        check("stall_hold", stall_bad, 0);
        check("gap_len", gap_bad, 0);
        check("sel_lock", sel_bad, 0);
        check("abort_next_cycle", abort_late, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
